// File: rtl/filter_pkg.sv
// Shared definitions for the rank-order filter family: FSM encodings and
// derived widths used by both the sorter and the trimmed-mean consumer.
package filter_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CAPT  = 4'b0010,
        S_ACCUM = 4'b0100,
        S_DIV   = 4'b1000
    } atm_state_e;

    function automatic int trim_count(input int dn, input int trim);
        return dn - 2 * trim;
    endfunction

    function automatic int sum_width(input int dn, input int dw);
        return dw + $clog2(dn);
    endfunction

    function automatic int seq_width(input int dn);
        return $clog2(dn);
    endfunction

endpackage

// File: rtl/alpha_trim_mean_divider.sv
// Sequential restoring divider by a constant: one quotient bit per cycle,
// MSB first; done_o and quotient_o are valid together in the final cycle.
module seq_divider #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned DIVISOR = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        fits   = (rem_sh >= (WIDTH + 1)'(DIVISOR));
        rem_d  = WIDTH'(fits ? rem_sh - (WIDTH + 1)'(DIVISOR) : rem_sh);
        quo_d  = {quo_q[WIDTH-2:0], fits};
    end

    assign busy_o     = (cnt_q != '0);
    assign done_o     = (cnt_q == CW'(1));
    // Exposing the next quotient lets the consumer latch it on the final step.
    assign quotient_o = quo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            cnt_q <= CW'(WIDTH);
        end else if (busy_o) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean of a sorted window: sums ranks TRIM..DN-1-TRIM and divides
// by their count. Define ALPHA_ROUND_EN for round-half-up instead of truncation.
module alpha_trim_mean
    import filter_pkg::*;
#(
    parameter int DN          = 25,
    parameter int DW          = 8,
    parameter int TRIM        = 6,
    parameter int DW_sequence = seq_width(DN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sort_finish,
    input  logic [DW*DN-1:0]          data_unsort,
    input  logic [DW_sequence*DN-1:0] sequence_sorted,
    output logic [DW-1:0]             mean_out,
    output logic                      mean_valid,
    output logic                      busy
);
    localparam int N  = trim_count(DN, TRIM);
    localparam int SW = sum_width(DN, DW);
`ifdef ALPHA_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(N / 2);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    atm_state_e             state_q, state_d;
    logic [DW-1:0]          data_q [DN];
    logic [DW_sequence-1:0] seq_q  [DN];
    logic [SW-1:0]          sum_q, sum_d;
    logic [DW_sequence-1:0] rank_q, rank_d;
    logic [DW-1:0]          mean_q, mean_d;
    logic                   valid_q, valid_d;
    logic                   div_start, div_busy, div_done;
    logic [SW-1:0]          div_dividend, div_quo;

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        rank_d       = rank_q;
        mean_d       = mean_q;
        valid_d      = 1'b0;
        div_start    = 1'b0;
        case (state_q)
            S_IDLE:  if (sort_finish) state_d = S_CAPT;
            S_CAPT: begin
                sum_d   = '0;
                rank_d  = DW_sequence'(TRIM);
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                sum_d  = sum_q + SW'(data_q[seq_q[rank_q]]);
                rank_d = rank_q + 1'b1;
                if (rank_q == DW_sequence'(DN - 1 - TRIM)) begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (div_busy && div_done) begin
                    mean_d  = DW'(div_quo);
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The divider loads on the last ACCUM edge, so it takes the updated sum.
        div_dividend = sum_d + RND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            rank_q  <= '0;
            mean_q  <= '0;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < DN; i++) begin
                data_q[i] <= '0;
                seq_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            rank_q  <= rank_d;
            mean_q  <= mean_d;
            valid_q <= valid_d;
            if (state_q == S_CAPT) begin
                for (int unsigned i = 0; i < DN; i++) begin
                    data_q[i] <= data_unsort[i*DW +: DW];
                    seq_q[i]  <= sequence_sorted[i*DW_sequence +: DW_sequence];
                end
            end
        end
    end

    seq_divider #(
        .WIDTH  (SW),
        .DIVISOR(N)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (div_start),
        .dividend_i(div_dividend),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    assign mean_out   = mean_q;
    assign mean_valid = valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Directed bench for alpha_trim_mean with default parameters (DN=25, DW=8, TRIM=6).
module tb_alpha_trim_mean;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sort_finish;
  logic [199:0] data_unsort;
  logic [124:0] sequence_sorted;
  logic [7:0]   mean_out;
  logic         mean_valid;
  logic         busy;

  int ncmp  = 0;
  int nfail = 0;

  alpha_trim_mean dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sort_finish    (sort_finish),
    .data_unsort    (data_unsort),
    .sequence_sorted(sequence_sorted),
    .mean_out       (mean_out),
    .mean_valid     (mean_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse sort_finish (cycle T0), then observe 40 cycles at the falling edge.
  task automatic run_window(input logic [199:0] d, input logic [124:0] s,
                            input int extra_at, input int rst_at,
                            output int lat, output int nv, output int val);
    lat = -1; nv = 0; val = 0;
    @(posedge clk); #1;
    data_unsort = d; sequence_sorted = s; sort_finish = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mean_valid === 1'b1) begin
        nv++;
        if (lat < 0) begin lat = c; val = int'(mean_out); end
      end
      if (rst_at < 0 && c == 1)  check("busy_T1", 32'(busy), 32'd1);
      if (rst_at < 0 && c == 27) check("busy_T27", 32'(busy), 32'd1);
      if (rst_at < 0 && c == 28) check("busy_T28", 32'(busy), 32'd0);
      if (c == 1) sort_finish = 1'b0;
      if (c == extra_at) begin
        sort_finish = 1'b1;
        data_unsort = {25{8'd200}};
      end
      if (c == extra_at + 1) sort_finish = 1'b0;
      if (c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 2) begin
        check("rst_mean_out", 32'(mean_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(mean_valid), 32'd0);
        rst_n = 1'b1;
      end
    end
  endtask

  logic [199:0] d;
  logic [124:0] s;
  logic [124:0] s_id;
  int lat, nv, val, r;

  initial begin
    rst_n = 1'b0; sort_finish = 1'b0; data_unsort = '0; sequence_sorted = '0;
    for (int i = 0; i < 25; i++) s_id[i*5 +: 5] = 5'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mean_out", 32'(mean_out), 32'd0);
    check("reset_valid", 32'(mean_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Flat window of 100s
    d = {25{8'd100}};
    run_window(d, s_id, -10, -10, lat, nv, val);
    check("flat_latency", lat, 28);
    check("flat_count", nv, 1);
    check("flat_mean", val, 100);

    // Ramp 0..24: kept 6..18, sum 156
    for (int i = 0; i < 25; i++) d[i*8 +: 8] = 8'(i);
    run_window(d, s_id, -10, -10, lat, nv, val);
    check("ramp_latency", lat, 28);
    check("ramp_mean", val, 12);

    // Outliers at indices 7 (0) and 19 (255)
    d = {25{8'd50}}; d[7*8 +: 8] = 8'd0; d[19*8 +: 8] = 8'd255;
    s[0 +: 5] = 5'd7; s[24*5 +: 5] = 5'd19; r = 1;
    for (int i = 0; i < 25; i++)
      if (i != 7 && i != 19) begin s[r*5 +: 5] = 5'(i); r++; end
    run_window(d, s, -10, -10, lat, nv, val);
    check("outlier_mean", val, 50);

    // Reversed storage of six 0, six 10, seven 11, six 255: kept sum 137
    for (int i = 0; i < 25; i++) begin
      r = 24 - i;
      d[i*8 +: 8] = (r < 6) ? 8'd0 : (r < 12) ? 8'd10 : (r < 19) ? 8'd11 : 8'd255;
      s[i*5 +: 5] = 5'(24 - i);
    end
    run_window(d, s, -10, -10, lat, nv, val);
`ifdef ALPHA_ROUND_EN
    check("round_mean", val, 11);
`else
    check("trunc_mean", val, 10);
`endif

    // Second sort_finish at T5 with different data must be ignored
    for (int i = 0; i < 25; i++) d[i*8 +: 8] = 8'(i);
    run_window(d, s_id, 5, -10, lat, nv, val);
    check("busy_pulse_latency", lat, 28);
    check("busy_pulse_count", nv, 1);
    check("busy_pulse_mean", val, 12);

    // Reset during DIV aborts the window
    d = {25{8'd50}};
    run_window(d, s_id, -10, 20, lat, nv, val);
    check("abort_count", nv, 0);

    // Fresh window after reset release
    d = {25{8'd77}};
    run_window(d, s_id, -10, -10, lat, nv, val);
    check("post_rst_latency", lat, 28);
    check("post_rst_count", nv, 1);
    check("post_rst_mean", val, 77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
